// File: rtl/tpu_avalon_ctrl_if.sv
// Avalon-MM slave bus bundle between the host and the tiny-TPU controller.
interface tpu_avalon_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) ();
    logic [ADDR_WIDTH-1:0]   slave_address;
    logic                    slave_read;
    logic                    slave_write;
    logic [DATA_WIDTH-1:0]   slave_writedata;
    logic [DATA_WIDTH/8-1:0] slave_byteenable;
    logic [DATA_WIDTH-1:0]   slave_readdata;
    logic                    slave_readdatavalid;

    modport slave (
        input  slave_address, slave_read, slave_write, slave_writedata, slave_byteenable,
        output slave_readdata, slave_readdatavalid
    );

    modport master (
        output slave_address, slave_read, slave_write, slave_writedata, slave_byteenable,
        input  slave_readdata, slave_readdatavalid
    );
endinterface

// File: rtl/tpu_avalon_ctrl.sv
// Avalon-MM front end, register file and run sequencer for the tiny-TPU array.
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_FILL  | N cycles, input FIFOs filling
//   S_LOADW | N cycles, weights shifting into the array
//   S_MULT  | ROWS+2N-1 cycles, multiply; last ROWS cycles write results
//   S_DONE  | one cycle, raises done on exit
module tpu_avalon_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MEM_AW     = ADDR_WIDTH - 2,
    parameter int ARRAY_DIM  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    tpu_avalon_ctrl_if.slave        av,
    output logic                    irq,
    output logic                    wr_en_weight,
    output logic                    wr_en_data,
    output logic [MEM_AW-1:0]       mem_wr_addr,
    output logic [DATA_WIDTH-1:0]   mem_wr_data,
    output logic [DATA_WIDTH/8-1:0] mem_byteenable,
    output logic [MEM_AW-1:0]       mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]   rd_data_weight,
    input  logic [DATA_WIDTH-1:0]   rd_data_input,
    input  logic [DATA_WIDTH-1:0]   rd_data_output,
    output logic [MEM_AW-1:0]       base_addr_weight,
    output logic [MEM_AW-1:0]       base_addr_data,
    output logic                    wr_en_fifo,
    output logic                    load_en_weight,
    output logic                    mult_en,
    output logic                    out_wr_en,
    output logic [MEM_AW-1:0]       wr_addr_output
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int KW = MEM_AW + 8;
    localparam logic [KW-1:0] K_N1  = KW'(ARRAY_DIM - 1);
    localparam logic [KW-1:0] K_2N1 = KW'(2 * ARRAY_DIM - 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_LOADW, S_MULT, S_DONE} state_t;

    state_t                r_state;
    logic [KW-1:0]         r_k;
    logic                  r_wr_en_fifo, r_load_en_weight, r_mult_en, r_out_wr_en;
    logic [MEM_AW-1:0]     r_wr_addr_output;
    logic                  r_start, r_irq_en, r_done, r_error;
    logic [MEM_AW-1:0]     r_wbase, r_ibase, r_obase;
    logic [MEM_AW:0]       r_rows;
    logic [MEM_AW-1:0]     r_wbase_s, r_ibase_s, r_obase_s;
    logic [MEM_AW:0]       r_rows_s;
    logic [31:0]           r_cycles;
    logic                  r_rd_valid;
    logic [1:0]            r_rd_region;
    logic [DATA_WIDTH-1:0] r_reg_rdata;

    logic [1:0]            w_region;
    logic [2:0]            w_off;
    logic [DATA_WIDTH-1:0] w_bmask, w_wd, w_reg_rdata;
    logic                  w_busy, w_reg_wr, w_start_req, w_start_ok, w_mem_wr_busy, w_stat_wr;
    logic [KW-1:0]         w_k_nx, w_mult_last;

    function automatic logic [DATA_WIDTH-1:0] f_merge(input logic [DATA_WIDTH-1:0] old_v,
                                                      input logic [DATA_WIDTH-1:0] new_v,
                                                      input logic [DATA_WIDTH-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    always_comb begin
        w_bmask = '0;
        for (int i = 0; i < BW; i++) w_bmask[8*i +: 8] = {8{av.slave_byteenable[i]}};
    end

    assign w_region      = av.slave_address[ADDR_WIDTH-1:ADDR_WIDTH-2];
    assign w_off         = av.slave_address[2:0];
    assign w_wd          = av.slave_writedata;
    // a start accepted but not yet acted on already counts as busy
    assign w_busy        = (r_state != S_IDLE) || r_start;
    assign w_reg_wr      = av.slave_write && (w_region == 2'b00);
    assign w_stat_wr     = w_reg_wr && (w_off == 3'd5) && av.slave_byteenable[0];
    assign w_start_req   = w_reg_wr && (w_off == 3'd0) && av.slave_byteenable[0] && w_wd[0];
    assign w_start_ok    = w_start_req && !w_busy && (r_rows != '0);
    assign w_mem_wr_busy = av.slave_write && w_busy && ((w_region == 2'b01) || (w_region == 2'b10));
    assign w_k_nx        = r_k + 1'b1;
    assign w_mult_last   = KW'(r_rows_s) + KW'(2 * ARRAY_DIM - 2);

    always_comb begin
        w_reg_rdata = '0;
        case (w_off)
            3'd0: w_reg_rdata = DATA_WIDTH'({r_irq_en, 2'b00});
            3'd1: w_reg_rdata = DATA_WIDTH'(r_wbase);
            3'd2: w_reg_rdata = DATA_WIDTH'(r_ibase);
            3'd3: w_reg_rdata = DATA_WIDTH'(r_obase);
            3'd4: w_reg_rdata = DATA_WIDTH'(r_rows);
            3'd5: w_reg_rdata = DATA_WIDTH'({r_error, r_done, w_busy});
            3'd6: w_reg_rdata = DATA_WIDTH'(r_cycles);
            default: w_reg_rdata = DATA_WIDTH'(32'h7075_0001);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_start     <= 1'b0;
            r_irq_en    <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_wbase     <= '0;
            r_ibase     <= '0;
            r_obase     <= '0;
            r_rows      <= '0;
            r_wbase_s   <= '0;
            r_ibase_s   <= '0;
            r_obase_s   <= '0;
            r_rows_s    <= '0;
            r_cycles    <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_region <= '0;
            r_reg_rdata <= '0;
        end else begin
            r_start <= w_start_ok;
            if (w_reg_wr) begin
                case (w_off)
                    3'd0: if (av.slave_byteenable[0]) r_irq_en <= w_wd[2];
                    3'd1: r_wbase <= MEM_AW'(f_merge(DATA_WIDTH'(r_wbase), w_wd, w_bmask));
                    3'd2: r_ibase <= MEM_AW'(f_merge(DATA_WIDTH'(r_ibase), w_wd, w_bmask));
                    3'd3: r_obase <= MEM_AW'(f_merge(DATA_WIDTH'(r_obase), w_wd, w_bmask));
                    3'd4: r_rows  <= (MEM_AW+1)'(f_merge(DATA_WIDTH'(r_rows), w_wd, w_bmask));
                    default: ;
                endcase
            end
            if (w_start_ok) begin
                r_wbase_s <= r_wbase;
                r_ibase_s <= r_ibase;
                r_obase_s <= r_obase;
                r_rows_s  <= r_rows;
            end
            if (w_stat_wr && w_wd[2]) r_error <= 1'b0;
            if ((w_start_req && !w_start_ok) || w_mem_wr_busy) r_error <= 1'b1;
            // DONE setting done outranks a simultaneous write-1-to-clear
            if (w_start_ok)                 r_done <= 1'b0;
            else if (r_state == S_DONE)     r_done <= 1'b1;
            else if (w_stat_wr && w_wd[1])  r_done <= 1'b0;
            if (w_start_ok)
                r_cycles <= '0;
            else if ((r_state != S_IDLE) && (r_cycles != '1))
                r_cycles <= r_cycles + 32'd1;
            r_rd_valid <= av.slave_read;
            if (av.slave_read) begin
                r_rd_region <= w_region;
                r_reg_rdata <= w_reg_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= S_IDLE;
            r_k              <= '0;
            r_wr_en_fifo     <= 1'b0;
            r_load_en_weight <= 1'b0;
            r_mult_en        <= 1'b0;
            r_out_wr_en      <= 1'b0;
            r_wr_addr_output <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (r_start) begin
                    r_state      <= S_FILL;
                    r_k          <= '0;
                    r_wr_en_fifo <= 1'b1;
                end
                S_FILL: if (r_k == K_N1) begin
                    r_state          <= S_LOADW;
                    r_k              <= '0;
                    r_wr_en_fifo     <= 1'b0;
                    r_load_en_weight <= 1'b1;
                end else r_k <= w_k_nx;
                S_LOADW: if (r_k == K_N1) begin
                    r_state          <= S_MULT;
                    r_k              <= '0;
                    r_load_en_weight <= 1'b0;
                    r_mult_en        <= 1'b1;
                end else r_k <= w_k_nx;
                S_MULT: if (r_k == w_mult_last) begin
                    r_state     <= S_DONE;
                    r_k         <= '0;
                    r_mult_en   <= 1'b0;
                    r_out_wr_en <= 1'b0;
                end else begin
                    r_k              <= w_k_nx;
                    r_out_wr_en      <= (w_k_nx >= K_2N1) && (w_k_nx <= w_mult_last);
                    r_wr_addr_output <= r_obase_s + MEM_AW'(w_k_nx - K_2N1);
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        case (r_rd_region)
            2'b00:   av.slave_readdata = r_reg_rdata;
            2'b01:   av.slave_readdata = rd_data_weight;
            2'b10:   av.slave_readdata = rd_data_input;
            default: av.slave_readdata = rd_data_output;
        endcase
    end

    assign av.slave_readdatavalid = r_rd_valid;
    assign irq              = r_done & r_irq_en;
    assign wr_en_weight     = av.slave_write && (w_region == 2'b01) && !w_busy;
    assign wr_en_data       = av.slave_write && (w_region == 2'b10) && !w_busy;
    assign mem_wr_addr      = av.slave_address[MEM_AW-1:0];
    assign mem_rd_addr      = av.slave_address[MEM_AW-1:0];
    assign mem_wr_data      = av.slave_writedata;
    assign mem_byteenable   = av.slave_byteenable;
    assign base_addr_weight = r_wbase_s;
    assign base_addr_data   = r_ibase_s;
    assign wr_en_fifo       = r_wr_en_fifo;
    assign load_en_weight   = r_load_en_weight;
    assign mult_en          = r_mult_en;
    assign out_wr_en        = r_out_wr_en;
    assign wr_addr_output   = r_wr_addr_output;
endmodule

// File: tb/tb_tpu_avalon_ctrl.sv
// Bench for tpu_avalon_ctrl: timeline model of a run checked every cycle, plus directed scenarios.
module tb_tpu_avalon_ctrl;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        irq, wr_en_weight, wr_en_data, wr_en_fifo, load_en_weight, mult_en, out_wr_en;
    logic [7:0]  mem_wr_addr, mem_rd_addr, base_addr_weight, base_addr_data, wr_addr_output;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_byteenable;
    logic [31:0] rd_data_weight = 32'h1234_5678;
    logic [31:0] rd_data_input  = 32'h2222_3333;
    logic [31:0] rd_data_output = 32'h4444_5555;

    int checks = 0;
    int errors = 0;

    tpu_avalon_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) av ();

    tpu_avalon_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .MEM_AW(8), .ARRAY_DIM(N)) dut (
        .clk(clk), .reset(rst_n), .av(av), .irq(irq),
        .wr_en_weight(wr_en_weight), .wr_en_data(wr_en_data),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_byteenable(mem_byteenable),
        .mem_rd_addr(mem_rd_addr),
        .rd_data_weight(rd_data_weight), .rd_data_input(rd_data_input), .rd_data_output(rd_data_output),
        .base_addr_weight(base_addr_weight), .base_addr_data(base_addr_data),
        .wr_en_fifo(wr_en_fifo), .load_en_weight(load_en_weight), .mult_en(mult_en),
        .out_wr_en(out_wr_en), .wr_addr_output(wr_addr_output)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a run is a timeline of t = clock edges since the accepted start write.
    bit   m_active, m_done, m_irq_en, m_error, m_pre, m_acc;
    int   m_t, m_rows, m_rows_s, m_obase, m_obase_s;
    logic [31:0] m_wd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_done = 0; m_irq_en = 0; m_error = 0;
            m_t = 0; m_rows = 0; m_rows_s = 0; m_obase = 0; m_obase_s = 0;
        end else begin
            m_pre = m_active;
            m_acc = 0;
            m_wd  = av.slave_writedata;
            if (av.slave_write) begin
                if (av.slave_address[9:8] == 2'b00) begin
                    case (av.slave_address[2:0])
                        3'd0: begin
                            m_irq_en = m_wd[2];
                            if (m_wd[0]) begin
                                if (m_pre || m_rows == 0) m_error = 1;
                                else m_acc = 1;
                            end
                        end
                        3'd3: m_obase = int'(m_wd[7:0]);
                        3'd4: m_rows  = int'(m_wd[8:0]);
                        3'd5: begin
                            if (m_wd[1]) m_done = 0;
                            if (m_wd[2]) m_error = 0;
                        end
                        default: ;
                    endcase
                end else if (av.slave_address[9:8] != 2'b11 && m_pre) m_error = 1;
            end
            if (m_pre) begin
                m_t++;
                if (m_t == 4*N + m_rows_s + 1) begin
                    m_done = 1;
                    m_active = 0;
                end
            end
            if (m_acc) begin
                m_active = 1; m_t = 0; m_done = 0;
                m_rows_s = m_rows; m_obase_s = m_obase;
            end
        end
    end

    bit   e_fill, e_load, e_mult, e_oe, e_ww, e_wd;
    int   e_k;
    logic [7:0] e_addr;

    always @(negedge clk) begin
        if (rst_n) begin
            e_fill = m_active && m_t >= 1 && m_t <= N;
            e_load = m_active && m_t >= N+1 && m_t <= 2*N;
            e_mult = m_active && m_t >= 2*N+1 && m_t <= 4*N + m_rows_s - 1;
            e_k    = m_t - (2*N+1);
            e_oe   = e_mult && e_k >= 2*N-1 && e_k <= m_rows_s + 2*N - 2;
            e_addr = 8'(m_obase_s + e_k - (2*N-1));
            e_ww   = av.slave_write && av.slave_address[9:8] == 2'b01 && !m_active;
            e_wd   = av.slave_write && av.slave_address[9:8] == 2'b10 && !m_active;
            chk("wr_en_fifo", wr_en_fifo, e_fill);
            chk("load_en_weight", load_en_weight, e_load);
            chk("mult_en", mult_en, e_mult);
            chk("out_wr_en", out_wr_en, e_oe);
            if (e_oe) chk("wr_addr_output", wr_addr_output, e_addr);
            chk("irq", irq, m_done & m_irq_en);
            chk("wr_en_weight", wr_en_weight, e_ww);
            chk("wr_en_data", wr_en_data, e_wd);
        end
    end

    // Phase activity tallies used by the literal run checks.
    int n_fifo = 0, n_load = 0, n_mult = 0;
    logic [7:0] addr_log[$];
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en_fifo) n_fifo++;
            if (load_en_weight) n_load++;
            if (mult_en) n_mult++;
            if (out_wr_en) addr_log.push_back(wr_addr_output);
        end
    end

    task automatic bus_write(input logic [9:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        av.slave_address = a; av.slave_writedata = d; av.slave_byteenable = 4'hF; av.slave_write = 1'b1;
        @(posedge clk); #1;
        av.slave_write = 1'b0;
    endtask

    task automatic bus_read(input logic [9:0] a, output logic [31:0] d, output logic v);
        @(posedge clk); #1;
        av.slave_address = a; av.slave_read = 1'b1;
        @(posedge clk); #1;
        av.slave_read = 1'b0;
        d = av.slave_readdata;
        v = av.slave_readdatavalid;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd;
    logic        vld;
    int          t, f0, l0, m0, a0;

    initial begin
        av.slave_address = '0; av.slave_read = 1'b0; av.slave_write = 1'b0;
        av.slave_writedata = '0; av.slave_byteenable = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enables", {wr_en_fifo, load_en_weight, mult_en, out_wr_en}, 0);
        chk("rst_rdvalid_irq", {av.slave_readdatavalid, irq}, 0);
        chk("rst_readdata", av.slave_readdata, 0);
        @(negedge clk) rst_n = 1'b1;

        bus_read(10'h007, rd, vld);
        chk("id_read", rd, 32'h7075_0001);
        chk("id_valid", vld, 1);
        @(posedge clk); #1;
        chk("valid_one_cycle", av.slave_readdatavalid, 0);

        // run N=4, ROWS=3, OBASE=FE with irq enabled
        bus_write(10'h003, 32'hFE);
        bus_write(10'h004, 32'd3);
        f0 = n_fifo; l0 = n_load; m0 = n_mult; a0 = addr_log.size();
        bus_write(10'h000, 32'h5);
        t = 0;
        forever begin
            @(negedge clk);
            if (irq) break;
            if (t >= 200) begin
                errors++;
                $display("FAIL done_wait: got timeout expected done");
                break;
            end
            @(posedge clk);
            t++;
        end
        chk("done_latency", t, 20);
        repeat (2) @(posedge clk);
        chk("fifo_cycles", n_fifo - f0, 4);
        chk("loadw_cycles", n_load - l0, 4);
        chk("mult_cycles", n_mult - m0, 10);
        chk("out_writes", addr_log.size() - a0, 3);
        if (addr_log.size() - a0 == 3) begin
            chk("out_addr0", addr_log[a0], 8'hFE);
            chk("out_addr1", addr_log[a0+1], 8'hFF);
            chk("out_addr2", addr_log[a0+2], 8'h00);
        end
        bus_read(10'h006, rd, vld);
        chk("cycles_reg", rd, 19);
        bus_read(10'h005, rd, vld);
        chk("status_done", rd, 32'h2);
        chk("irq_high", irq, 1);

        // weight memory write with partial byte enables, then readbacks
        @(posedge clk); #1;
        av.slave_address = 10'h105; av.slave_writedata = 32'hA5A5_A5A5;
        av.slave_byteenable = 4'b0011; av.slave_write = 1'b1;
        @(negedge clk);
        chk("wmem_wr_en", wr_en_weight, 1);
        chk("wmem_addr", mem_wr_addr, 8'h05);
        chk("wmem_be", mem_byteenable, 4'b0011);
        chk("wmem_data", mem_wr_data, 32'hA5A5_A5A5);
        @(posedge clk); #1;
        av.slave_write = 1'b0;
        bus_read(10'h105, rd, vld);
        chk("wmem_read", rd, 32'h1234_5678);
        chk("wmem_read_valid", vld, 1);
        bus_read(10'h2A0, rd, vld);
        chk("imem_read", rd, 32'h2222_3333);
        bus_read(10'h3A0, rd, vld);
        chk("omem_read", rd, 32'h4444_5555);

        // start while busy and input-memory write while busy
        bus_write(10'h000, 32'h1);
        repeat (3) @(posedge clk);
        bus_write(10'h000, 32'h1);
        @(posedge clk); #1;
        av.slave_address = 10'h210; av.slave_writedata = 32'hDEAD; av.slave_byteenable = 4'hF;
        av.slave_write = 1'b1;
        @(negedge clk);
        chk("busy_wr_en_data", wr_en_data, 0);
        @(posedge clk); #1;
        av.slave_write = 1'b0;
        repeat (30) @(posedge clk);
        bus_read(10'h005, rd, vld);
        chk("status_err_done", rd, 32'h6);
        bus_read(10'h006, rd, vld);
        chk("cycles_second", rd, 19);
        bus_write(10'h005, 32'h4);
        bus_read(10'h005, rd, vld);
        chk("status_err_clr", rd, 32'h2);

        // irq clear by write-1-to-clear of done
        bus_write(10'h000, 32'h4);
        chk("irq_en_done", irq, 1);
        bus_write(10'h005, 32'h2);
        chk("irq_cleared", irq, 0);

        // ROWS=0 start is rejected
        bus_write(10'h004, 32'h0);
        bus_write(10'h000, 32'h5);
        repeat (5) @(posedge clk);
        bus_read(10'h005, rd, vld);
        chk("rows0_status", rd, 32'h4);
        chk("rows0_irq", irq, 0);
        bus_write(10'h005, 32'h4);

        // reset in the middle of MULT
        bus_write(10'h004, 32'd3);
        bus_write(10'h000, 32'h1);
        t = 0;
        forever begin
            @(negedge clk);
            if (mult_en) break;
            if (t >= 100) begin
                errors++;
                $display("FAIL mult_wait: got timeout expected mult_en");
                break;
            end
            t++;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_enables", {wr_en_fifo, load_en_weight, mult_en, out_wr_en}, 0);
        chk("midrst_addr", wr_addr_output, 0);
        chk("midrst_valid_irq", {av.slave_readdatavalid, irq}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (30) @(posedge clk);
        bus_read(10'h005, rd, vld);
        chk("post_rst_status", rd, 0);
        bus_read(10'h000, rd, vld);
        chk("post_rst_ctrl", rd, 0);
        bus_read(10'h007, rd, vld);
        chk("post_rst_id", rd, 32'h7075_0001);
        chk("post_rst_id_valid", vld, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
